// File: rtl/param_gshare_predictor_if.sv
// Fetch/resolve bundle between the pipeline and the gshare predictor.
// The pipeline drives the master side; the predictor is the slave.
interface param_gshare_predictor_if #(
   parameter int GHR_BITS = 8
);
   logic [31:0]         getir_ps_i;
   logic                getir_ps_gecerli;
   logic [31:0]         buyruk_i;
   logic                tahmin_gecerli_o;
   logic                sonuc_dallan_o;
   logic [31:0]         sonuc_dallan_ps_o;
   logic [GHR_BITS-1:0] tahmin_ghr_o;
   logic                yurut_ps_gecerli;
   logic [31:0]         yurut_ps_i;
   logic [GHR_BITS-1:0] yurut_ghr_i;
   logic                yurut_atladi_i;
   logic                yurut_yanlis_tahmin;

   modport master (
      output getir_ps_i, getir_ps_gecerli, buyruk_i,
      output yurut_ps_gecerli, yurut_ps_i, yurut_ghr_i, yurut_atladi_i, yurut_yanlis_tahmin,
      input  tahmin_gecerli_o, sonuc_dallan_o, sonuc_dallan_ps_o, tahmin_ghr_o
   );

   modport slave (
      input  getir_ps_i, getir_ps_gecerli, buyruk_i,
      input  yurut_ps_gecerli, yurut_ps_i, yurut_ghr_i, yurut_atladi_i, yurut_yanlis_tahmin,
      output tahmin_gecerli_o, sonuc_dallan_o, sonuc_dallan_ps_o, tahmin_ghr_o
   );
endinterface

// File: rtl/param_gshare_predictor.sv
// Gshare predictor: 2-bit counters indexed by PC xor speculative history, one-cycle
// registered prediction with B-type target and history recovery on mispredict.
module param_gshare_predictor #(
   parameter int PHT_BITS = 8,
   parameter int GHR_BITS = 8,
   parameter int PC_LSB   = 2
) (
   input logic                     clk_i,
   input logic                     rst_i,
   param_gshare_predictor_if.slave bus
);
   localparam int PHT_N = 1 << PHT_BITS;

   function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic up);
      if (up) return (cnt == 2'd3) ? 2'd3 : cnt + 2'd1;
      else    return (cnt == 2'd0) ? 2'd0 : cnt - 2'd1;
   endfunction

   function automatic logic [31:0] b_offset(input logic [31:0] instr);
      return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   endfunction

   logic [1:0]          pht [PHT_N];
   logic [GHR_BITS-1:0] ghr;
   logic [GHR_BITS-1:0] ghr_nxt;
   logic [PHT_BITS-1:0] fetch_idx;
   logic [PHT_BITS-1:0] upd_idx;
   logic                is_br;
   logic                recover;
   logic                fetch_ok;
   logic                pred_p0;
   logic [31:0]         target_p0;
   logic                vld_p1;
   logic                taken_p1;
   logic [31:0]         target_p1;
   logic [GHR_BITS-1:0] hist_p1;
   logic                unused_bits;

   assign fetch_idx = bus.getir_ps_i[PC_LSB+PHT_BITS-1:PC_LSB] ^ PHT_BITS'(ghr);
   assign upd_idx   = bus.yurut_ps_i[PC_LSB+PHT_BITS-1:PC_LSB] ^ PHT_BITS'(bus.yurut_ghr_i);
   assign is_br     = (bus.buyruk_i[6:0] == 7'b1100011);
   assign recover   = bus.yurut_ps_gecerli & bus.yurut_yanlis_tahmin;
   // A fetch that coincides with recovery is on the wrong path, so it is dropped.
   assign fetch_ok  = bus.getir_ps_gecerli & ~recover;
   // Counter is read before this edge's update lands, so same-index updates are not forwarded.
   assign pred_p0   = is_br & pht[fetch_idx][1];
   assign target_p0 = bus.getir_ps_i + b_offset(bus.buyruk_i);
   assign unused_bits = ^{bus.yurut_ps_i, bus.buyruk_i[24:12]};

   // Truncating casts keep {history[GHR_BITS-2:0], bit} and also cover GHR_BITS == 1.
   always_comb begin
      ghr_nxt = ghr;
      if (recover)
         ghr_nxt = GHR_BITS'({bus.yurut_ghr_i, bus.yurut_atladi_i});
      else if (fetch_ok && is_br)
         ghr_nxt = GHR_BITS'({ghr, pred_p0});
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < PHT_N; i++) pht[i] <= 2'd1;
      end else if (bus.yurut_ps_gecerli) begin
         pht[upd_idx] <= sat_update(pht[upd_idx], bus.yurut_atladi_i);
      end
   end

   // p0 -> p1: registered prediction; target and history hold while no valid fetch.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ghr       <= '0;
         vld_p1    <= 1'b0;
         taken_p1  <= 1'b0;
         target_p1 <= '0;
         hist_p1   <= '0;
      end else begin
         ghr      <= ghr_nxt;
         vld_p1   <= fetch_ok;
         taken_p1 <= fetch_ok & pred_p0;
         if (fetch_ok) begin
            target_p1 <= target_p0;
            hist_p1   <= ghr;
         end
      end
   end

   assign bus.tahmin_gecerli_o  = vld_p1;
   assign bus.sonuc_dallan_o    = taken_p1;
   assign bus.sonuc_dallan_ps_o = target_p1;
   assign bus.tahmin_ghr_o      = hist_p1;
endmodule

// File: tb/tb_param_gshare_predictor.sv
// Directed bench for param_gshare_predictor with an array/arithmetic reference model
// and a negedge compare process, plus literal expectations at key points.
module tb_param_gshare_predictor;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   param_gshare_predictor_if #(.GHR_BITS(8)) bus ();

   param_gshare_predictor #(.PHT_BITS(8), .GHR_BITS(8), .PC_LSB(2)) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   int          total = 0;
   int          bad   = 0;
   int          m_pht [256];
   int          m_ghr;
   bit          e_vld;
   bit          e_tk;
   logic [31:0] e_tgt;
   logic [7:0]  e_ghr;
   bit          chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] enc_b(input int imm);
      logic [12:0] b;
      b = 13'(imm);
      return {b[12], b[10:5], 5'd0, 5'd0, 3'd0, b[4:1], b[11], 7'b1100011};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 256; i++) m_pht[i] = 1;
      m_ghr = 0;
      e_vld = 0;
      e_tk  = 0;
      e_tgt = '0;
      e_ghr = '0;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("vld",   {31'd0, bus.tahmin_gecerli_o}, {31'd0, e_vld});
         check("taken", {31'd0, bus.sonuc_dallan_o},   {31'd0, e_tk});
         check("tgt",   bus.sonuc_dallan_ps_o,         e_tgt);
         check("ghr",   {24'd0, bus.tahmin_ghr_o},     {24'd0, e_ghr});
      end
   end

   task automatic step(input bit fv, input bit br, input logic [31:0] pc, input int imm,
                       input bit rv, input logic [31:0] rpc, input logic [7:0] rghr,
                       input bit rt, input bit rmis);
      int idx;
      int uidx;
      bit pred;
      bit mis;
      bit fok;
      bus.getir_ps_gecerli    = fv;
      bus.getir_ps_i          = pc;
      bus.buyruk_i            = br ? enc_b(imm) : 32'h0000_0013;
      bus.yurut_ps_gecerli    = rv;
      bus.yurut_ps_i          = rpc;
      bus.yurut_ghr_i         = rghr;
      bus.yurut_atladi_i      = rt;
      bus.yurut_yanlis_tahmin = rmis;
      @(posedge clk);
      mis  = rv && rmis;
      fok  = fv && !mis;
      idx  = int'((pc >> 2) & 32'hFF) ^ m_ghr;
      pred = br && (m_pht[idx] >= 2);
      e_vld = fok;
      e_tk  = fok && pred;
      if (fok) begin
         e_tgt = pc + (br ? 32'(imm) : 32'd0);
         e_ghr = 8'(m_ghr);
      end
      if (rv) begin
         uidx = int'((rpc >> 2) & 32'hFF) ^ int'(rghr);
         if (rt) m_pht[uidx] = (m_pht[uidx] == 3) ? 3 : m_pht[uidx] + 1;
         else    m_pht[uidx] = (m_pht[uidx] == 0) ? 0 : m_pht[uidx] - 1;
      end
      if (mis)             m_ghr = ((int'(rghr) << 1) | int'(rt)) & 255;
      else if (fok && br)  m_ghr = ((m_ghr << 1) | int'(pred)) & 255;
      #1;
   endtask

   task automatic fetch(input bit br, input logic [31:0] pc, input int imm);
      step(1'b1, br, pc, imm, 1'b0, 32'd0, 8'd0, 1'b0, 1'b0);
   endtask

   task automatic resolve(input logic [31:0] rpc, input logic [7:0] rghr, input bit rt);
      step(1'b0, 1'b0, 32'd0, 0, 1'b1, rpc, rghr, rt, 1'b0);
   endtask

   task automatic lit(input string tag, input bit v, input bit t, input logic [31:0] tg,
                      input logic [7:0] g);
      check({tag, "_vld"},   {31'd0, bus.tahmin_gecerli_o}, {31'd0, v});
      check({tag, "_taken"}, {31'd0, bus.sonuc_dallan_o},   {31'd0, t});
      check({tag, "_tgt"},   bus.sonuc_dallan_ps_o,         tg);
      check({tag, "_ghr"},   {24'd0, bus.tahmin_ghr_o},     {24'd0, g});
   endtask

   task automatic idle_inputs();
      bus.getir_ps_gecerli    = 1'b0;
      bus.getir_ps_i          = '0;
      bus.buyruk_i            = '0;
      bus.yurut_ps_gecerli    = 1'b0;
      bus.yurut_ps_i          = '0;
      bus.yurut_ghr_i         = '0;
      bus.yurut_atladi_i      = 1'b0;
      bus.yurut_yanlis_tahmin = 1'b0;
   endtask

   initial begin
      idle_inputs();
      #1 rst = 1'b1;
      model_reset();
      chk_en = 1'b1;
      #1 lit("reset", 1'b0, 1'b0, 32'h0, 8'h00);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // First beq after reset: weak not-taken, target 0x110.
      fetch(1'b1, 32'h100, 16);
      lit("beq_first", 1'b1, 1'b0, 32'h110, 8'h00);

      // Two taken resolves train index 0x40 to strong taken.
      resolve(32'h100, 8'h00, 1'b1);
      resolve(32'h100, 8'h00, 1'b1);
      fetch(1'b1, 32'h100, 16);
      lit("trained", 1'b1, 1'b1, 32'h110, 8'h00);

      // Saturate high, then two decrements leave the counter at 1 (history now 0x01).
      repeat (5) resolve(32'h100, 8'h00, 1'b1);
      repeat (2) resolve(32'h100, 8'h00, 1'b0);
      fetch(1'b1, 32'h104, 16);
      lit("sat_hi", 1'b1, 1'b0, 32'h114, 8'h01);

      // Floor at 0, then two taken give 2 (history now 0x02, index 0x42^0x02).
      repeat (3) resolve(32'h100, 8'h00, 1'b0);
      repeat (2) resolve(32'h100, 8'h00, 1'b1);
      fetch(1'b1, 32'h108, 16);
      lit("sat_lo", 1'b1, 1'b1, 32'h118, 8'h02);

      // Mispredict recovery with a same-cycle fetch.
      step(1'b1, 1'b1, 32'h300, 8, 1'b1, 32'h400, 8'h5A, 1'b1, 1'b1);
      lit("recover", 1'b0, 1'b0, 32'h118, 8'h02);
      fetch(1'b0, 32'h304, 0);
      lit("recover_ghr", 1'b1, 1'b0, 32'h304, 8'hB5);

      // Target arithmetic: negative offset and 32-bit wraparound.
      fetch(1'b1, 32'h200, -8);
      check("tgt_neg", bus.sonuc_dallan_ps_o, 32'h1F8);
      fetch(1'b1, 32'hFFFF_FFF0, 32);
      check("tgt_wrap", bus.sonuc_dallan_ps_o, 32'h0000_0010);

      // Same-index fetch and update: fetch sees pre-update value.
      step(1'b0, 1'b0, 32'd0, 0, 1'b1, 32'h800, 8'h00, 1'b0, 1'b1);
      step(1'b1, 1'b1, 32'h140, 4, 1'b1, 32'h140, 8'h00, 1'b1, 1'b0);
      lit("same_idx", 1'b1, 1'b0, 32'h144, 8'h00);
      fetch(1'b1, 32'h140, 4);
      lit("same_idx_next", 1'b1, 1'b1, 32'h144, 8'h00);

      // Mixed traffic checked by the reference model only.
      for (int k = 0; k < 48; k++) begin
         step(1'b1, (k % 3) != 0, 32'h1000 + 32'(k * 28), ((k % 3) != 0) ? (k * 12 - 200) : 0,
              (k % 2) == 1, 32'h1000 + 32'((k % 5) * 4), 8'(k * 37), (k % 3) == 1,
              (k % 11) == 5);
      end

      // Asynchronous reset between edges with traffic in flight.
      bus.getir_ps_gecerli = 1'b1;
      bus.getir_ps_i       = 32'h100;
      bus.buyruk_i         = enc_b(16);
      bus.yurut_ps_gecerli = 1'b1;
      bus.yurut_ps_i       = 32'h100;
      bus.yurut_ghr_i      = 8'h00;
      bus.yurut_atladi_i   = 1'b1;
      #2 rst = 1'b1;
      model_reset();
      #1 lit("async_rst", 1'b0, 1'b0, 32'h0, 8'h00);
      idle_inputs();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      fetch(1'b1, 32'h100, 16);
      lit("post_rst", 1'b1, 1'b0, 32'h110, 8'h00);
      fetch(1'b0, 32'h104, 0);

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
